// File: rtl/lfsr_rng_sched.sv
// Serves words from an external XNOR LFSR to two requesters through a round-robin arbiter.
// Each seeding is followed by a fixed warm-up so the first words are not trivially related to the seed.
module lfsr_rng_sched #(
   parameter int                  NUM_BITS     = 4,
   parameter int                  WARMUP       = 4,
   parameter logic [NUM_BITS-1:0] SEED_DEFAULT = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NUM_BITS-1:0] seed_i,
   input  logic                seed_load_i,
   input  logic [1:0]          req_i,
   output logic [1:0]          gnt_o,
   output logic [NUM_BITS-1:0] data_o,
   output logic                data_valid_o,
   output logic                wrap_o,
   output logic                ready_o,
   output logic                err_o,
   output logic                lfsr_rst_n_o,
   output logic                lfsr_en_o,
   output logic [NUM_BITS-1:0] lfsr_seed_o,
   input  logic [NUM_BITS-1:0] lfsr_data_i,
   input  logic                lfsr_done_i
);

   typedef enum logic [1:0] {SEED, WARM, READY} state_t;

   state_t              state_reg;
   logic [7:0]          warm_cnt_reg;
   logic [NUM_BITS-1:0] seed_reg;
   logic [NUM_BITS-1:0] data_reg;
   logic [1:0]          gnt_reg;
   logic                valid_reg;
   logic                wrap_reg;
   logic                err_reg;
   logic                prio_reg;   // 1 while requester 1 holds priority

   logic                load_ok;
   logic                load_bad;
   logic [1:0]          elig;
   logic                sel_any;
   logic                sel_idx;

   // All-ones is the XNOR lock-up value and can never leave itself.
   assign load_ok  = seed_load_i & ~(&seed_i);
   assign load_bad = seed_load_i &  (&seed_i);

   assign elig    = req_i & ~gnt_reg;
   assign sel_any = ~rst_i & ~load_ok & (state_reg == READY) & (|elig);
   assign sel_idx = (elig == 2'b11) ? prio_reg : elig[1];

   assign lfsr_en_o    = ~rst_i & ((state_reg == WARM) | sel_any);
   assign lfsr_rst_n_o = ~rst_i & (state_reg != SEED);

   // Outputs are forced to their reset values for as long as reset is held, aborting any pending grant.
   assign gnt_o        = rst_i ? 2'b00 : gnt_reg;
   assign data_valid_o = ~rst_i & valid_reg;
   assign wrap_o       = ~rst_i & wrap_reg;
   assign err_o        = ~rst_i & err_reg;
   assign ready_o      = ~rst_i & (state_reg == READY);
   assign data_o       = rst_i ? '0 : data_reg;
   assign lfsr_seed_o  = rst_i ? SEED_DEFAULT : seed_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= SEED;
         warm_cnt_reg <= '0;
         seed_reg     <= SEED_DEFAULT;
         data_reg     <= '0;
         gnt_reg      <= 2'b00;
         valid_reg    <= 1'b0;
         wrap_reg     <= 1'b0;
         err_reg      <= 1'b0;
         prio_reg     <= 1'b0;
      end else begin
         gnt_reg   <= sel_any ? (sel_idx ? 2'b10 : 2'b01) : 2'b00;
         valid_reg <= sel_any;
         wrap_reg  <= sel_any & lfsr_done_i;
         err_reg   <= load_bad;
         if (sel_any) begin
            data_reg <= lfsr_data_i;
            prio_reg <= ~sel_idx;
         end
         if (load_ok) begin
            seed_reg     <= seed_i;
            state_reg    <= SEED;
            warm_cnt_reg <= '0;
            prio_reg     <= 1'b0;
         end else begin
            case (state_reg)
               SEED: begin
                  state_reg    <= WARM;
                  warm_cnt_reg <= '0;
               end
               WARM: begin
                  warm_cnt_reg <= warm_cnt_reg + 8'd1;
                  if (warm_cnt_reg == 8'(WARMUP - 1)) begin
                     state_reg <= READY;
                  end
               end
               READY:   state_reg <= READY;
               default: state_reg <= SEED;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Bench for lfsr_rng_sched: an environment LFSR, a sequence-level reference model checked every cycle,
// and directed scenarios with hand-computed words.
module tb_lfsr_rng_sched;

   localparam int NB = 4;
   localparam int WU = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [NB-1:0] seed_i = '0;
   logic          seed_load_i = 1'b0;
   logic [1:0]    req_i = 2'b00;
   logic [1:0]    gnt_o;
   logic [NB-1:0] data_o;
   logic          data_valid_o, wrap_o, ready_o, err_o;
   logic          lfsr_rst_n_o, lfsr_en_o;
   logic [NB-1:0] lfsr_seed_o;
   logic [NB-1:0] lfsr_data_i;
   logic          lfsr_done_i;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   lfsr_rng_sched #(.NUM_BITS(NB), .WARMUP(WU), .SEED_DEFAULT(4'b0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .seed_i(seed_i), .seed_load_i(seed_load_i),
      .req_i(req_i), .gnt_o(gnt_o), .data_o(data_o), .data_valid_o(data_valid_o),
      .wrap_o(wrap_o), .ready_o(ready_o), .err_o(err_o),
      .lfsr_rst_n_o(lfsr_rst_n_o), .lfsr_en_o(lfsr_en_o), .lfsr_seed_o(lfsr_seed_o),
      .lfsr_data_i(lfsr_data_i), .lfsr_done_i(lfsr_done_i)
   );

   always #5 clk_i = ~clk_i;

   // n steps of the 4-bit XNOR LFSR (taps 3 and 2, shifting left).
   function automatic logic [NB-1:0] lfsr_word(input logic [NB-1:0] s, input int n);
      logic [NB-1:0] v;
      v = s;
      for (int i = 0; i < n; i++) v = {v[2:0], ~(v[3] ^ v[2])};
      return v;
   endfunction

   // Environment LFSR attached to the DUT.
   logic [NB-1:0] env_val;
   always @(posedge clk_i) begin
      if (!lfsr_rst_n_o)  env_val <= lfsr_seed_o;
      else if (lfsr_en_o) env_val <= lfsr_word(env_val, 1);
   end
   assign lfsr_data_i = env_val;
   assign lfsr_done_i = (env_val == lfsr_seed_o);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase counts cycles since seeding (0 = seed cycle, 1..WU warm-up, beyond = serving);
   // every served word is simply the (WU + served)-th successor of the seed.
   int            m_phase = 0;
   int            m_served = 0;
   int            m_last = 1;
   logic [NB-1:0] m_seed = '0;
   logic [1:0]    x_gnt = '0;
   logic          x_valid = 0, x_wrap = 0, x_err = 0;
   logic [NB-1:0] x_data = '0;

   initial begin
      forever begin
         @(posedge clk_i);
         if (rst_i) begin
            m_phase = 0; m_served = 0; m_last = 1; m_seed = '0;
            x_gnt = '0; x_valid = 0; x_wrap = 0; x_err = 0; x_data = '0;
         end else begin
            logic       acc;
            logic [1:0] el;
            int         pick;
            acc = seed_load_i && (seed_i != 4'b1111);
            el  = req_i & ~x_gnt;
            if (m_phase > WU && !acc && el != 0) begin
               pick     = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
               x_data   = lfsr_word(m_seed, WU + m_served);
               x_wrap   = (x_data == m_seed);
               x_gnt    = (pick == 1) ? 2'b10 : 2'b01;
               x_valid  = 1;
               m_served = m_served + 1;
               m_last   = pick;
            end else begin
               x_gnt = '0; x_valid = 0; x_wrap = 0;
            end
            x_err = seed_load_i && (seed_i == 4'b1111);
            if (acc) begin
               m_seed = seed_i; m_phase = 0; m_served = 0; m_last = 1;
            end else if (m_phase < 1000) begin
               m_phase = m_phase + 1;
            end
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (chk_en) begin
            logic r, accn, selm;
            r    = rst_i;
            accn = seed_load_i && (seed_i != 4'b1111);
            selm = !r && (m_phase > WU) && !accn && ((req_i & ~x_gnt) != 0);
            chk("cyc_gnt",   int'(gnt_o),        r ? 0 : int'(x_gnt));
            chk("cyc_valid", int'(data_valid_o), r ? 0 : int'(x_valid));
            chk("cyc_data",  int'(data_o),       r ? 0 : int'(x_data));
            chk("cyc_wrap",  int'(wrap_o),       r ? 0 : int'(x_wrap));
            chk("cyc_err",   int'(err_o),        r ? 0 : int'(x_err));
            chk("cyc_ready", int'(ready_o),      (!r && m_phase > WU) ? 1 : 0);
            chk("cyc_seed",  int'(lfsr_seed_o),  r ? 0 : int'(m_seed));
            chk("cyc_rst_n", int'(lfsr_rst_n_o), (!r && m_phase != 0) ? 1 : 0);
            chk("cyc_en",    int'(lfsr_en_o),
                (!r && ((m_phase >= 1 && m_phase <= WU) || selm)) ? 1 : 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_grant(output int cyc, output logic [1:0] g, output logic [NB-1:0] d,
                             output logic w);
      bit got;
      got = 0; cyc = 0; g = '0; d = '0; w = 0;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         if (data_valid_o) begin
            got = 1; g = gnt_o; d = data_o; w = wrap_o;
         end
      end
      chk("grant_timeout", int'(got), 1);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready_o && n < 20) begin
         tick();
         n++;
      end
   endtask

   int            n, cyc, gtotal, extra;
   logic [1:0]    g, gprev;
   logic [NB-1:0] d;
   logic          w;
   logic [NB-1:0] lit0 [3];

   initial begin
      lit0[0] = 4'b1110; lit0[1] = 4'b1101; lit0[2] = 4'b1011;
      tick();
      chk_en = 1'b1;
      tick(); tick();
      chk("rst_ready", int'(ready_o), 0);
      chk("rst_rst_n", int'(lfsr_rst_n_o), 0);
      chk("rst_en",    int'(lfsr_en_o), 0);
      chk("rst_gnt",   int'(gnt_o), 0);

      // One seed cycle plus four warm-up cycles, then requester 0 alone.
      rst_i = 1'b0;
      req_i = 2'b01;
      wait_ready(n);
      chk("ready_latency", n, 5);
      gtotal = 0;
      for (int i = 0; i < 3; i++) begin
         wait_grant(cyc, g, d, w);
         gtotal++;
         $display("grant %0d gnt=%b data=%b wrap=%b", gtotal, g, d, w);
         chk("solo_gnt", int'(g), 1);
         chk("solo_word", int'(d), int'(lit0[i]));
      end

      // Both requesters: alternating, back-to-back.
      gprev = 2'b01;
      req_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_grant(cyc, g, d, w);
         gtotal++;
         $display("grant %0d gnt=%b data=%b wrap=%b", gtotal, g, d, w);
         chk("alt_b2b", cyc, 1);
         chk("alt_flip", int'(g != gprev), 1);
         gprev = g;
      end

      // Requester 0 holds until it sees its grant, then drops: one word only.
      req_i = 2'b01;
      wait_grant(cyc, g, d, w);
      gtotal++;
      $display("grant %0d gnt=%b data=%b wrap=%b", gtotal, g, d, w);
      req_i = 2'b00;
      chk("hold_gnt", int'(g), 1);
      extra = 0;
      repeat (4) begin
         tick();
         if (data_valid_o) extra++;
      end
      chk("hold_single", extra, 0);

      // Grants 9..15; the 12th serves 0000 and is the only wrap. A rejected load rides along.
      req_i = 2'b11;
      while (gtotal < 15) begin
         if (gtotal == 13) begin
            seed_load_i = 1'b1; seed_i = 4'b1111;
         end
         wait_grant(cyc, g, d, w);
         gtotal++;
         $display("grant %0d gnt=%b data=%b wrap=%b err=%b", gtotal, g, d, w, err_o);
         chk("wrap_flag", int'(w), (gtotal == 12) ? 1 : 0);
         if (gtotal == 12) chk("wrap_word", int'(d), 0);
         if (gtotal == 14) begin
            chk("reject_err", int'(err_o), 1);
            chk("reject_b2b", cyc, 1);
            seed_load_i = 1'b0;
         end
      end
      req_i = 2'b00;
      tick();
      chk("reject_seed_kept", int'(lfsr_seed_o), 0);

      // Reseed to reach warm-up, then reseed with 0101 in the middle of it.
      seed_load_i = 1'b1; seed_i = 4'b0000;
      tick();
      seed_load_i = 1'b0;
      tick(); tick();
      seed_load_i = 1'b1; seed_i = 4'b0101;
      tick();
      seed_load_i = 1'b0;
      wait_ready(n);
      chk("reseed_latency", n + 1, 6);
      chk("reseed_seed", int'(lfsr_seed_o), 5);
      req_i = 2'b01;
      wait_grant(cyc, g, d, w);
      $display("reseed grant gnt=%b data=%b wrap=%b", g, d, w);
      chk("reseed_word0", int'(d), 0);
      chk("reseed_wrap0", int'(w), 0);
      wait_grant(cyc, g, d, w);
      $display("reseed grant gnt=%b data=%b wrap=%b", g, d, w);
      chk("reseed_word1", int'(d), 1);

      // Reset raised in the cycle the grant would be presented.
      tick();
      chk("pre_rst_idle", int'(data_valid_o), 0);
      tick();
      chk("pre_rst_grant", int'(data_valid_o), 1);
      rst_i = 1'b1;
      #1;
      chk("abort_gnt",   int'(gnt_o), 0);
      chk("abort_valid", int'(data_valid_o), 0);
      chk("abort_data",  int'(data_o), 0);
      tick(); tick();
      chk("abort_ready", int'(ready_o), 0);
      chk("abort_seed",  int'(lfsr_seed_o), 0);
      rst_i = 1'b0;
      req_i = 2'b00;
      repeat (8) tick();
      chk("post_rst_ready", int'(ready_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_rng_sched.md
LFSR_RNG_SCHED -- requirements
Module: lfsr_rng_sched

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, which sets the LFSR width (3..32).
REQ-002 The block SHALL have parameter WARMUP, default 4, which sets the number of LFSR advances after each seeding before words are served (1..255).
REQ-003 The block SHALL have parameter SEED_DEFAULT, default 0, which is the seed used after reset.
REQ-004 The block SHALL have port clk_i, input, width 1: the single clock, with all state updated on the rising edge.
REQ-005 The block SHALL have port rst_i, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port seed_i, input, width NUM_BITS: the new seed value.
REQ-007 The block SHALL have port seed_load_i, input, width 1: a one-cycle pulse requesting a reseed with seed_i.
REQ-008 The block SHALL have port req_i, input, width 2: level requests from requesters 0 and 1.
REQ-009 The block SHALL have port gnt_o, output, width 2: a registered one-hot grant pulse.
REQ-010 The block SHALL have port data_o, output, width NUM_BITS: the registered random word.
REQ-011 The block SHALL have port data_valid_o, output, width 1: qualifies data_o and is coincident with gnt_o.
REQ-012 The block SHALL have port wrap_o, output, width 1: asserted with data_valid_o when the served word equals the current seed.
REQ-013 The block SHALL have port ready_o, output, width 1: high while the state is READY.
REQ-014 The block SHALL have port err_o, output, width 1: a one-cycle pulse on a rejected seed load.
REQ-015 The block SHALL have port lfsr_rst_n_o, output, width 1: the active-low synchronous seed-load strobe to the LFSR.
REQ-016 The block SHALL have port lfsr_en_o, output, width 1: the LFSR advance enable.
REQ-017 The block SHALL have port lfsr_seed_o, output, width NUM_BITS: the seed to the LFSR, held stable between loads.
REQ-018 The block SHALL have port lfsr_data_i, input, width NUM_BITS: the current LFSR value.
REQ-019 The block SHALL have port lfsr_done_i, input, width 1: the LFSR flag that its current value equals lfsr_seed_o.

Function
REQ-020 The FSM SHALL have exactly the states SEED, WARM and READY.
REQ-021 In SEED, the block SHALL drive lfsr_rst_n_o=0 and lfsr_en_o=0 for exactly one cycle, then go to WARM with the warm counter cleared.
REQ-022 In WARM, the block SHALL drive lfsr_en_o=1 every cycle, go to READY after exactly WARMUP cycles, and issue no grants.
REQ-023 In READY, in a cycle where any eligible req_i bit is high, the block SHALL select one requester by round-robin and drive lfsr_en_o=1 in that same cycle (combinational).
REQ-024 In the cycle after a selection, the block SHALL drive gnt_o one-hot, data_valid_o=1, and data_o = the lfsr_data_i value sampled in the selection cycle (the value before the advance).
REQ-025 The block SHALL assert wrap_o in that same cycle if lfsr_done_i was high in the selection cycle.
REQ-026 The block SHALL make at most one selection per cycle and SHALL allow back-to-back selections in consecutive cycles.
REQ-027 Round-robin: the requester not granted last SHALL have priority, and requester 0 SHALL have priority after reset or a reseed.
REQ-028 A requester whose gnt_o is high in the current cycle SHALL be ineligible in that cycle, so a request held until the grant is seen yields exactly one word.
REQ-029 With both requesters continuously eligible, grants SHALL alternate 0,1,0,1...
REQ-030 When seed_load_i=1 and seed_i is not all-ones, in any state, the block SHALL capture seed_i into lfsr_seed_o, go to SEED next cycle, suppress any selection that cycle, and reset the round-robin pointer.
REQ-031 When seed_load_i=1 and seed_i is all-ones (the XNOR lock-up state), the block SHALL reject the load, pulse err_o the next cycle, leave the seed and state unchanged, and still process requests normally.
REQ-032 A reseed issued during WARM SHALL restart the sequence at SEED and the full WARMUP count SHALL repeat.
REQ-033 Outside grant cycles, gnt_o and data_valid_o SHALL be 0, wrap_o SHALL be 0, and data_o SHALL hold its last value.

Reset
REQ-034 While rst_i=1, the block SHALL set state to SEED, lfsr_seed_o=SEED_DEFAULT, gnt_o=0, data_o=0, data_valid_o=0, wrap_o=0, err_o=0, ready_o=0, and the round-robin pointer to favor requester 0.
REQ-035 While rst_i=1, the block SHALL drive lfsr_en_o=0 and lfsr_rst_n_o=0.
REQ-036 After rst_i releases, the block SHALL perform the SEED cycle and then WARM.
REQ-037 A reset asserted mid-grant or mid-WARM SHALL abort the operation and drop any pending grant.

Verification
REQ-038 Scenario: NUM_BITS=4, WARMUP=4, SEED_DEFAULT=0; release reset, then hold req_i=01 -> 1 SEED cycle and 4 WARM cycles, ready_o=1; successive grants to requester 0 serve data_o 1110, 1101, 1011.
REQ-039 Scenario: req_i=11 held in READY -> gnt_o alternates 01,10,01,10; each data_valid_o carries the next LFSR word with no gaps.
REQ-040 Scenario: requester 0 holds req until gnt_o is seen, then drops it -> exactly one grant results.
REQ-041 Scenario: 15 consecutive grants from seed 0000 -> wrap_o=1 only with the word 0000 (the 12th grant, as WARMUP=4 advances the sequence).
REQ-042 Scenario: seed_load_i with seed_i=1111 -> err_o pulses and the served sequence is uninterrupted; then seed_i=0101 during WARM -> new SEED cycle, then 4 WARM cycles, then serving resumes from the 0101 sequence.
REQ-043 Scenario: rst_i asserted the cycle after a selection -> gnt_o and data_valid_o stay 0, and all outputs take their reset values.
